line_window_gen: RTL and testbench
==================================

Name: line_window_gen

Overview:
- Upstream neighbour of the 3x3 convolution engine.
- Accepts a raster-order 8-bit pixel stream, one pixel per cycle at most.
- Buffers two previous image rows and produces every valid-position 3x3 neighbourhood as a packed 72-bit vector with a one-cycle valid strobe.
- Output bus and strobe drive the engine's img_vector / img_vector_valid inputs directly; there is no backpressure.

Parameters:
- IMG_WIDTH, 64, pixels per row; must be at least 3.
- IMG_HEIGHT, 64, rows per frame; must be at least 3.
- PIX_W, 8, bits per pixel; the window bus is 9*PIX_W wide.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pixel_in  in  PIX_W  raster pixel data.
- pixel_in_valid  in  1  pixel_in is valid this cycle; always accepted, no ready signal.
- pixel_in_sof  in  1  qualifies pixel_in_valid; marks pixel (row 0, col 0) of a frame.
- img_vector  out  9*PIX_W  packed 3x3 window.
- img_vector_valid  out  1  one-cycle strobe; img_vector is valid.
- frame_done  out  1  one-cycle pulse, coincident with the last window of a frame.
- frame_err  out  1  one-cycle pulse when a pixel is dropped in IDLE, or when sof aborts a frame.

Behaviour:
- Reset (async assert, synchronous deassert use):
  - Outputs: img_vector=0, img_vector_valid=0, frame_done=0, frame_err=0.
  - Internal: row/col counters=0, window registers=0, state=IDLE.
  - Line-buffer contents are don't-care.
- State machine:
  - IDLE:
    - valid&&sof: accept the pixel as (0,0) and go to ACTIVE.
    - valid&&!sof: drop the pixel and pulse frame_err.
  - ACTIVE:
    - Each valid pixel advances col; at col==IMG_WIDTH-1, col wraps to 0 and row increments.
    - Pixel (IMG_WIDTH-1, IMG_HEIGHT-1) returns the block to IDLE.
    - valid&&sof in ACTIVE: pulse frame_err, restart with this pixel as (0,0), stay ACTIVE.
    - Gaps (valid=0) hold all state; there is no timeout.
- Storage:
  - Two row memories, lb0 (older) and lb1 (newer), each IMG_WIDTH x PIX_W.
  - 3x3 window registers win[r][c]: r=0 oldest row, c=2 newest column.
- Per accepted pixel at column col, all updates happen on the same edge:
  - win[r][0]<=win[r][1] and win[r][1]<=win[r][2].
  - win[0][2]<=lb0[col], win[1][2]<=lb1[col], win[2][2]<=pixel_in.
  - lb0[col]<=lb1[col] and lb1[col]<=pixel_in.
  - Memory read-before-write at the same address: the old value is used.
- Emission:
  - A window is emitted for an accepted pixel with row>=2 && col>=2.
  - img_vector_valid=1 on the cycle after acceptance, with img_vector = the updated window.
  - Latency: 1 cycle from the completing pixel.
  - img_vector holds its value between strobes.
  - Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2).
  - Windows never span a row boundary, because col>=2 gating flushes the stale columns.
- Packing:
  - Byte k = img_vector[PIX_W*k +: PIX_W] = win[k/3][k%3].
  - Byte 0 is top-left; byte 8 is bottom-right (the newest pixel).
  - Bytes are passed raw; there is no sign interpretation.
- frame_done: asserted in the same cycle as the img_vector_valid produced by the frame's final pixel.
- Restart after sof abort:
  - Stale line-buffer data is harmless because emission is gated by row>=2.
  - Row counting restarts from 0.
- Reset mid-frame: all windows in flight are discarded; there is no partial emission.
- Counter widths: $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT).

Decomposition:
- Shared package cnn_pkg holds:
  - PIX_W.
  - KERNEL_TAPS=9.
  - Window bus width WIN_W=KERNEL_TAPS*PIX_W.
  - State enum {IDLE, ACTIVE}.
- One natural sub-module: line_ram, a single-port read-before-write row memory of depth IMG_WIDTH, instantiated twice.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = raster index 0..15):
- Continuous frame, sof on pixel 0:
  - Exactly 4 strobes.
  - First strobe arrives 1 cycle after pixel 10, with bytes 0..8 = 0,1,2,4,5,6,8,9,10.
  - Last strobe has bytes 5,6,7,9,10,11,13,14,15, with frame_done high in the same cycle.
- Same frame with valid deasserted every other cycle: identical 4 vectors in the same order; the strobe follows each completing pixel by 1 cycle.
- Pixels sent in IDLE without sof: frame_err pulses once per pixel, no strobes, state stays IDLE.
- sof again at raster index 6:
  - frame_err pulses.
  - The following 16 pixels (values 100..115) produce 4 windows; the first is 100,101,102,104,105,106,108,109,110.
- rst_n pulsed low after pixel 9:
  - All outputs go 0 immediately (asynchronous).
  - No strobe follows.
  - A fresh frame afterward gives the results of the first test.
- Back-to-back frames (sof on the cycle after the final pixel):
  - 8 strobes total, 2 frame_done pulses, no frame_err.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and widths for the CNN front-end: pixel width, 3x3 window bus width, and the line-window FSM states.
package cnn_pkg;
  localparam int PIX_W       = 8;
  localparam int KERNEL_TAPS = 9;
  localparam int WIN_W       = KERNEL_TAPS * PIX_W;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;
endpackage

// File: rtl/line_window_gen_if.sv
// Pixel stream in, 3x3 window stream out. The master side is the pixel source, which also consumes the windows.
interface line_window_gen_if ();
  import cnn_pkg::*;

  logic [PIX_W-1:0] pixel_in;
  logic             pixel_in_valid;
  logic             pixel_in_sof;
  logic [WIN_W-1:0] img_vector;
  logic             img_vector_valid;
  logic             frame_done;
  logic             frame_err;

  modport master (
    output pixel_in, pixel_in_valid, pixel_in_sof,
    input  img_vector, img_vector_valid, frame_done, frame_err
  );

  modport slave (
    input  pixel_in, pixel_in_valid, pixel_in_sof,
    output img_vector, img_vector_valid, frame_done, frame_err
  );
endinterface

// File: rtl/line_ram.sv
// Single-port row memory: asynchronous read, synchronous write, so a same-address read returns the pre-write value.
module line_ram
  import cnn_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [PIX_W-1:0] i_wdata,
  output logic [PIX_W-1:0] o_rdata
);
  logic [PIX_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/line_window_gen.sv
// Raster pixel stream to 3x3 neighbourhood generator: two row buffers plus a 3x3 shift window.
// state  | meaning
// IDLE   | waiting for sof; pixels without sof are dropped and flagged
// ACTIVE | frame in progress; col/row track the next pixel position
module line_window_gen
  import cnn_pkg::*;
#(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input logic               clk,
  input logic               rst_n,
  line_window_gen_if.slave  bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_col, w_col, w_col_nxt;
  logic [RW-1:0]    r_row, w_row, w_row_nxt;
  logic             w_accept, w_last, w_emit, w_err;
  logic [PIX_W-1:0] w_lb0_rd, w_lb1_rd;
  logic [PIX_W-1:0] r_win     [3][3];
  logic [PIX_W-1:0] w_win_nxt [3][3];
  logic [WIN_W-1:0] w_vec;
  logic [WIN_W-1:0] r_img_vector;
  logic             r_img_valid, r_frame_done, r_frame_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // sof always repositions the incoming pixel to (0,0), which also covers the mid-frame restart
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_err       = 1'b0;
    w_col       = bus.pixel_in_sof ? '0 : r_col;
    w_row       = bus.pixel_in_sof ? '0 : r_row;
    case (r_state)
      IDLE: begin
        if (bus.pixel_in_valid) begin
          if (bus.pixel_in_sof) begin
            w_accept    = 1'b1;
            w_state_nxt = ACTIVE;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (bus.pixel_in_valid) begin
          w_accept = 1'b1;
          w_err    = bus.pixel_in_sof;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_last = (w_col == COL_LAST) && (w_row == ROW_LAST);
    w_emit = w_accept && (w_row >= RW'(2)) && (w_col >= CW'(2));
    if (w_accept && w_last) w_state_nxt = IDLE;
    w_col_nxt = r_col;
    w_row_nxt = r_row;
    if (w_accept) begin
      if (w_col == COL_LAST) begin
        w_col_nxt = '0;
        w_row_nxt = w_last ? '0 : w_row + 1'b1;
      end else begin
        w_col_nxt = w_col + 1'b1;
        w_row_nxt = w_row;
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_win_nxt[r][0] = r_win[r][1];
      w_win_nxt[r][1] = r_win[r][2];
    end
    w_win_nxt[0][2] = w_lb0_rd;
    w_win_nxt[1][2] = w_lb1_rd;
    w_win_nxt[2][2] = bus.pixel_in;
    w_vec = '0;
    for (int k = 0; k < KERNEL_TAPS; k++) begin
      w_vec[PIX_W*k +: PIX_W] = w_win_nxt[k/3][k%3];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_img_vector <= '0;
      r_img_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) r_win[r][c] <= '0;
      end
    end else begin
      r_col        <= w_col_nxt;
      r_row        <= w_row_nxt;
      r_img_valid  <= w_emit;
      r_frame_done <= w_emit && w_last;
      r_frame_err  <= w_err;
      if (w_accept) r_win <= w_win_nxt;
      if (w_emit)   r_img_vector <= w_vec;
    end
  end

  // lb0 takes lb1's old row while lb1 takes the new pixel: the rows shift up by one
  line_ram #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb0 (
    .clk     (clk),
    .i_we    (w_accept),
    .i_addr  (w_col),
    .i_wdata (w_lb1_rd),
    .o_rdata (w_lb0_rd)
  );

  line_ram #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb1 (
    .clk     (clk),
    .i_we    (w_accept),
    .i_addr  (w_col),
    .i_wdata (bus.pixel_in),
    .o_rdata (w_lb1_rd)
  );

  assign bus.img_vector       = r_img_vector;
  assign bus.img_vector_valid = r_img_valid;
  assign bus.frame_done       = r_frame_done;
  assign bus.frame_err        = r_frame_err;
endmodule

// File: tb/tb_line_window_gen.sv
// Scoreboard bench for line_window_gen on a 4x4 image: the driver queues expected windows, the monitor pops on each strobe.
module tb_line_window_gen;
  import cnn_pkg::*;

  localparam int W = 4;
  localparam int H = 4;

  typedef struct {
    logic [WIN_W-1:0] vec;
    logic             done;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  line_window_gen_if bus ();

  line_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t q[$];
  exp_t m_e;
  int cyc = 0;
  int n_chk = 0, n_pass = 0;
  int n_strobe = 0, n_done = 0, n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [WIN_W-1:0] got, input logic [WIN_W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Window whose bottom-right pixel is at (row,col); pixel value = base + raster index
  function automatic logic [WIN_W-1:0] win_vec(input int base, input int row, input int col);
    logic [WIN_W-1:0] v;
    v = '0;
    for (int k = 0; k < 9; k++)
      v[PIX_W*k +: PIX_W] = PIX_W'(base + (row - 2 + k/3) * W + (col - 2 + k%3));
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.frame_err)  n_err++;
      if (bus.frame_done) n_done++;
      if (bus.img_vector_valid) begin
        n_strobe++;
        if (q.size() == 0) begin
          chk("unexpected_strobe", WIN_W'(bus.img_vector_valid), '0);
        end else begin
          m_e = q.pop_front();
          chk("window", bus.img_vector, m_e.vec);
          chk("frame_done", WIN_W'(bus.frame_done), WIN_W'(m_e.done));
          chk("latency", WIN_W'(cyc), WIN_W'(m_e.cyc));
        end
      end else if (bus.frame_done) begin
        chk("done_without_strobe", WIN_W'(bus.img_vector_valid), WIN_W'(1));
      end
    end
  end

  task automatic send(input int val, input bit sof, input int row, input int col, input int base, input bit track);
    bus.pixel_in       = PIX_W'(val);
    bus.pixel_in_valid = 1'b1;
    bus.pixel_in_sof   = sof;
    @(posedge clk);
    #1;
    if (track && row >= 2 && col >= 2)
      q.push_back('{vec: win_vec(base, row, col), done: (row == H-1 && col == W-1), cyc: cyc});
    bus.pixel_in_valid = 1'b0;
    bus.pixel_in_sof   = 1'b0;
  endtask

  task automatic gap();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int base, input bit gaps);
    for (int i = 0; i < W*H; i++) begin
      send(base + i, i == 0, i / W, i % W, base, 1'b1);
      if (gaps) gap();
    end
  endtask

  task automatic end_test(input string name, input int es, input int ed, input int ee);
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_strobes"}, WIN_W'(n_strobe), WIN_W'(es));
    chk({name, "_dones"},   WIN_W'(n_done),   WIN_W'(ed));
    chk({name, "_errs"},    WIN_W'(n_err),    WIN_W'(ee));
    chk({name, "_pending"}, WIN_W'(q.size()), '0);
    q.delete();
    n_strobe = 0;
    n_done   = 0;
    n_err    = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    bus.pixel_in       = '0;
    bus.pixel_in_valid = 1'b0;
    bus.pixel_in_sof   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vector", bus.img_vector, '0);
    chk("rst_valid",  WIN_W'(bus.img_vector_valid), '0);
    chk("rst_done",   WIN_W'(bus.frame_done), '0);
    chk("rst_err",    WIN_W'(bus.frame_err), '0);
    rst_n = 1'b1;
    gap();

    send_frame(0, 1'b0);
    end_test("cont", 4, 1, 0);

    send_frame(0, 1'b1);
    end_test("gaps", 4, 1, 0);

    for (int i = 0; i < 3; i++) send(7 + i, 1'b0, 0, 0, 0, 1'b0);
    end_test("idle", 0, 0, 3);

    for (int i = 0; i < 6; i++) send(i, i == 0, i / W, i % W, 0, 1'b0);
    send_frame(100, 1'b0);
    end_test("abort", 4, 1, 1);

    // img_vector still holds the previous frame's last window, so reset must visibly clear it
    for (int i = 0; i < 10; i++) send(i, i == 0, i / W, i % W, 0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_vector", bus.img_vector, '0);
    chk("async_rst_valid",  WIN_W'(bus.img_vector_valid), '0);
    chk("async_rst_done",   WIN_W'(bus.frame_done), '0);
    chk("async_rst_err",    WIN_W'(bus.frame_err), '0);
    gap();
    rst_n = 1'b1;
    for (int i = 10; i < 16; i++) send(i, 1'b0, i / W, i % W, 0, 1'b0);
    end_test("reset", 0, 0, 6);
    send_frame(0, 1'b0);
    end_test("after_reset", 4, 1, 0);

    send_frame(0, 1'b0);
    send_frame(200, 1'b0);
    end_test("b2b", 8, 2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
